// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers and width constants.
//   GRAY_W_DEF - default counter width
//   GRAY_W_MAX - widest value the helper functions accept
//   bin2gray   - binary to Gray, width-generic on zero-extended operands
//   gray2bin   - Gray to binary, width-generic on zero-extended operands
package gray_pkg;

    localparam int unsigned GRAY_W_DEF = 4;
    localparam int unsigned GRAY_W_MAX = 32;

    typedef logic [GRAY_W_MAX-1:0] gray_word_t;

    // Zero-extended inputs convert correctly, so callers cast to/from GRAY_W_MAX.
    function automatic gray_word_t bin2gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Prefix XOR from the MSB; zero upper bits leave the low bits unaffected.
    function automatic gray_word_t gray2bin(input gray_word_t g);
        gray_word_t b;
        b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
        for (int i = int'(GRAY_W_MAX) - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// gray2bin_n: combinational width-generic Gray-to-binary decoder.
//   gray     in  WIDTH  Gray-coded value
//   binary_c out WIDTH  decoded binary value (combinational)
module gray2bin_n
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_W_DEF
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary_c
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign binary_c[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_counter.sv
// gray_counter: up/down counter held in binary, presented as registered Gray and binary.
//   clk       in  1      rising-edge clock
//   rst_n     in  1      asynchronous active-low reset
//   clr       in  1      synchronous clear, highest priority
//   load      in  1      synchronous load of load_gray
//   load_gray in  WIDTH  Gray-coded load value
//   en        in  1      count enable
//   up        in  1      1 = increment, 0 = decrement
//   gray      out WIDTH  registered Gray count
//   binary    out WIDTH  registered binary count
//   term      out 1      one-cycle flag on a wrap or a blocked saturating step
module gray_counter
    import gray_pkg::*;
#(
    parameter int unsigned WIDTH = GRAY_W_DEF,
    parameter bit          WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] binary,
    output logic             term
);

    localparam logic [WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    if (WIDTH < 2 || WIDTH > GRAY_W_MAX) begin : g_bad_width
        $error("gray_counter: WIDTH out of range");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] load_bin_c;
    logic             term_q;
    logic             term_d;

    // Load path decode.
    gray2bin_n #(.WIDTH(WIDTH)) u_load_dec (
        .gray     (load_gray),
        .binary_c (load_bin_c)
    );

    // Priority mux with end-of-range detect; only counting steps can raise term.
    always_comb begin
        cnt_d  = cnt_q;
        term_d = 1'b0;
        if (clr) begin
            cnt_d = CNT_ZERO;
        end else if (load) begin
            cnt_d = load_bin_c;
        end else if (en) begin
            if (up) begin
                if (cnt_q == CNT_MAX) begin
                    term_d = 1'b1;
                    if (WRAP) cnt_d = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + WIDTH'(1);
                end
            end else begin
                if (cnt_q == CNT_ZERO) begin
                    term_d = 1'b1;
                    if (WRAP) cnt_d = CNT_MAX;
                end else begin
                    cnt_d = cnt_q - WIDTH'(1);
                end
            end
        end
    end

    // Gray is registered from the next count so it always matches binary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_ZERO;
            gray_q <= CNT_ZERO;
            term_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= WIDTH'(bin2gray(GRAY_W_MAX'(cnt_d)));
            term_q <= term_d;
        end
    end

    assign gray   = gray_q;
    assign binary = cnt_q;
    assign term   = term_q;

endmodule

// File: tb/tb_gray_counter.sv
// tb_gray_counter: directed plus randomized checks of wrapping and saturating counters.
module tb_gray_counter;

    localparam int unsigned W    = 4;
    localparam int          MAXV = 15;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         clr   = 1'b0;
    logic         load  = 1'b0;
    logic [W-1:0] load_gray = '0;
    logic         en    = 1'b0;
    logic         up    = 1'b0;

    logic [W-1:0] gray_w, bin_w, gray_s, bin_s;
    logic         term_w, term_s;

    always #5 clk = ~clk;

    gray_counter #(.WIDTH(W), .WRAP(1'b1)) dut_w (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_gray(load_gray),
        .en(en), .up(up), .gray(gray_w), .binary(bin_w), .term(term_w)
    );

    gray_counter #(.WIDTH(W), .WRAP(1'b0)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_gray(load_gray),
        .en(en), .up(up), .gray(gray_s), .binary(bin_s), .term(term_s)
    );

    int checks = 0;
    int passes = 0;
    int mw = 0, ms = 0;   // model counts: wrapping, saturating
    int tw = 0, ts = 0;   // model term flags

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Decode by search: the binary value whose Gray image is g.
    function automatic int decode(input int g);
        for (int b = 0; b <= MAXV; b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    function automatic int g_of(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic model_step();
        tw = 0;
        ts = 0;
        if (!rst_n) begin
            mw = 0; ms = 0;
        end else if (clr) begin
            mw = 0; ms = 0;
        end else if (load) begin
            mw = decode(int'(load_gray));
            ms = mw;
        end else if (en && up) begin
            if (mw == MAXV) begin mw = 0; tw = 1; end else mw = mw + 1;
            if (ms == MAXV) ts = 1; else ms = ms + 1;
        end else if (en) begin
            if (mw == 0) begin mw = MAXV; tw = 1; end else mw = mw - 1;
            if (ms == 0) ts = 1; else ms = ms - 1;
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, " wrap.binary"}, 32'(bin_w),  32'(mw));
        check({ph, " wrap.gray"},   32'(gray_w), 32'(g_of(mw)));
        check({ph, " wrap.term"},   32'(term_w), 32'(tw));
        check({ph, " sat.binary"},  32'(bin_s),  32'(ms));
        check({ph, " sat.gray"},    32'(gray_s), 32'(g_of(ms)));
        check({ph, " sat.term"},    32'(term_s), 32'(ts));
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        #1;
        model_step();
        check_all(ph);
    endtask

    task automatic set_ctl(input logic c, input logic l, input logic [W-1:0] lg,
                           input logic e, input logic u);
        clr = c; load = l; load_gray = lg; en = e; up = u;
    endtask

    initial begin
        logic [W-1:0] prev;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #1;
        mw = 0; ms = 0; tw = 0; ts = 0;
        check_all("reset_async");
        tick("reset_held");
        rst_n = 1'b1;

        // Load decode.
        set_ctl(1'b0, 1'b1, 4'b1110, 1'b0, 1'b0);
        tick("load_1110");
        check("load_1110 lit.binary", 32'(bin_w), 32'd11);
        check("load_1110 lit.gray", 32'(gray_w), 32'd14);
        set_ctl(1'b0, 1'b1, 4'b0100, 1'b0, 1'b0);
        tick("load_0100");
        check("load_0100 lit.binary", 32'(bin_w), 32'd7);

        // Single up step 0111 -> 1000.
        set_ctl(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        tick("up_step");
        check("up_step lit.binary", 32'(bin_w), 32'd8);
        check("up_step lit.gray", 32'(gray_w), 32'd12);

        // One Gray bit changes per edge over 16 enabled cycles, across a wrap.
        for (int i = 0; i < 16; i++) begin
            prev = gray_w;
            tick("gray_walk");
            check("gray_walk onebit", 32'($countones(prev ^ gray_w)), 32'd1);
        end

        // Up at max: wrap vs saturate; then term drops.
        set_ctl(1'b0, 1'b1, 4'b1000, 1'b0, 1'b0);
        tick("load_1000");
        check("load_1000 lit.binary", 32'(bin_w), 32'd15);
        set_ctl(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        tick("wrap_up");
        check("wrap_up lit.term", 32'(term_w), 32'd1);
        tick("sat_up2");
        tick("sat_up3");
        check("sat_up3 lit.binary", 32'(bin_s), 32'd15);
        check("sat_up3 lit.term", 32'(term_s), 32'd1);
        set_ctl(1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
        tick("clr_after_sat");
        check("clr_after_sat lit.term", 32'(term_s), 32'd0);

        // Down at zero.
        set_ctl(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        tick("wrap_down");
        check("wrap_down lit.gray", 32'(gray_w), 32'd8);
        set_ctl(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0);
        tick("term_drop");

        // Priority: load over count, clear over load.
        set_ctl(1'b0, 1'b1, 4'b0111, 1'b1, 1'b1);
        tick("load_en");
        check("load_en lit.binary", 32'(bin_w), 32'd5);
        set_ctl(1'b1, 1'b1, 4'b0111, 1'b1, 1'b1);
        tick("clr_load");

        // Reset mid-run at binary 1010, between edges.
        set_ctl(1'b0, 1'b1, 4'b1101, 1'b0, 1'b0);
        tick("load_1001");
        set_ctl(1'b0, 1'b0, 4'b0000, 1'b1, 1'b1);
        tick("run_1010");
        check("run_1010 lit.binary", 32'(bin_w), 32'd10);
        #2 rst_n = 1'b0;
        #1;
        mw = 0; ms = 0; tw = 0; ts = 0;
        check_all("reset_midrun");
        #1 rst_n = 1'b1;
        tick("resume");

        // Randomized traffic; direction changes rarely so the ends get exercised.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            clr  = (r < 3);
            load = (r >= 3 && r < 10);
            load_gray = W'($urandom_range(0, MAXV));
            en   = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 9) == 0) up = ~up;
            tick("random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
